// File: rtl/e_alloc.sv
// e_alloc: W-slot allocator. Keeps an occupancy map, offers the first free slot found
// by a circular search starting at a rotating pointer, and releases slots by mask.
module e_alloc #(
  parameter int W       = 32,
  parameter int RADIX_N = 4,
  parameter int RR      = 1
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic                   alloc_rdy_i,
  input  logic                   free_vld_i,
  input  logic [W-1:0]           free_vec_i,
  output logic                   alloc_vld_o,
  output logic [$clog2(W)-1:0]   alloc_idx_o,
  output logic [W-1:0]           alloc_vec_o,
  output logic [W-1:0]           busy_o,
  output logic [$clog2(W+1)-1:0] count_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic                   err_o
);

  localparam int IW = $clog2(W);
  localparam int CW = $clog2(W + 1);

  function automatic int tree_levels(input int w, input int r);
    int l;
    int p;
    l = 0;
    p = 1;
    if (r < 2) return 1;
    while (p < w) begin
      p = p * r;
      l = l + 1;
    end
    return l;
  endfunction

  localparam int LV = tree_levels(W, RADIX_N);
  localparam int NL = RADIX_N ** LV;
  localparam int PW = $clog2(NL);

  if (W < 2) begin : g_bad_w
    $error("e_alloc: W must be at least 2");
  end
  if (RADIX_N < 2 || RADIX_N > 8) begin : g_bad_radix
    $error("e_alloc: RADIX_N must be in [2,8]");
  end

  // Radix-RADIX_N reduction tree returning {found, index of lowest set bit}.
  // Reduction is done in place: group g only reads entries g*RADIX_N.. >= g.
  function automatic logic [IW:0] first_set(input logic [W-1:0] v);
    logic [NL-1:0] vld;
    logic [PW-1:0] idx [NL];
    logic          f;
    logic [PW-1:0] s;
    int            n;
    vld = '0;
    for (int i = 0; i < NL; i++) idx[i] = PW'(i);
    for (int i = 0; i < W; i++) vld[i] = v[i];
    n = NL;
    for (int l = 0; l < LV; l++) begin
      n = n / RADIX_N;
      for (int g = 0; g < n; g++) begin
        f = 1'b0;
        s = '0;
        for (int k = RADIX_N - 1; k >= 0; k--) begin
          if (vld[g*RADIX_N+k]) begin
            f = 1'b1;
            s = idx[g*RADIX_N+k];
          end
        end
        vld[g] = f;
        idx[g] = s;
      end
    end
    return {vld[0], IW'(idx[0])};
  endfunction

  logic [W-1:0]  busy_q, busy_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;

  logic [W-1:0]  freeVec, fromPtr, freeMask, legalFree;
  logic [IW:0]   hitHi, hitAll;
  logic [IW-1:0] searchIdx;
  logic          offer, accept;

  // Circular search = first free at/after ptr, else first free overall.
  always_comb begin
    freeVec = ~busy_q;
    for (int i = 0; i < W; i++) fromPtr[i] = (i >= int'(ptr_q));
    hitHi     = first_set(freeVec & fromPtr);
    hitAll    = first_set(freeVec);
    searchIdx = hitHi[IW] ? hitHi[IW-1:0] : hitAll[IW-1:0];
  end

  assign full_o      = (count_q == CW'(W));
  assign empty_o     = (count_q == '0);
  assign alloc_vld_o = ~full_o;
  assign offer       = alloc_vld_o & hitAll[IW];
  assign alloc_idx_o = offer ? searchIdx : '0;
  assign alloc_vec_o = offer ? (W'(1) << searchIdx) : '0;
  assign busy_o      = busy_q;
  assign count_o     = count_q;
  assign err_o       = err_q;

  // Accepted slot is set after frees apply, so an accepted-and-freed slot ends busy.
  always_comb begin
    accept    = alloc_vld_o & alloc_rdy_i;
    freeMask  = free_vld_i ? free_vec_i : '0;
    legalFree = freeMask & busy_q;
    busy_d    = busy_q & ~legalFree;
    if (accept) busy_d = busy_d | alloc_vec_o;
    count_d = CW'(int'(count_q) + int'(accept) - $countones(legalFree));
    err_d   = |(freeMask & ~busy_q);
    ptr_d   = ptr_q;
    if (RR == 0) begin
      ptr_d = '0;
    end else if (accept) begin
      ptr_d = (alloc_idx_o == IW'(W - 1)) ? '0 : alloc_idx_o + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      busy_q  <= '0;
      ptr_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_e_alloc.sv
// tb_e_alloc: directed + random stimulus on three e_alloc builds (W=8 RR=1, W=8 RR=0,
// W=12 RR=1); a behavioural model pushes expected snapshots to a scoreboard queue.
module tb_e_alloc;

  logic        clk;
  logic        arst_n;
  logic        rdyA, fvldA;
  logic [7:0]  fvecA;
  logic        rdyB, fvldB;
  logic [11:0] fvecB;

  logic        vldA, fullA, emptyA, errA;
  logic [2:0]  idxA;
  logic [7:0]  vecA, busyA;
  logic [3:0]  cntA;
  logic        vldF, fullF, emptyF, errF;
  logic [2:0]  idxF;
  logic [7:0]  vecF, busyF;
  logic [3:0]  cntF;
  logic        vldB, fullB, emptyB, errB;
  logic [3:0]  idxB;
  logic [11:0] vecB, busyB;
  logic [3:0]  cntB;

  e_alloc #(.W(8), .RADIX_N(4), .RR(1)) dutA (
    .clk(clk), .arst_n(arst_n), .alloc_rdy_i(rdyA), .free_vld_i(fvldA), .free_vec_i(fvecA),
    .alloc_vld_o(vldA), .alloc_idx_o(idxA), .alloc_vec_o(vecA), .busy_o(busyA),
    .count_o(cntA), .full_o(fullA), .empty_o(emptyA), .err_o(errA));

  e_alloc #(.W(8), .RADIX_N(2), .RR(0)) dutF (
    .clk(clk), .arst_n(arst_n), .alloc_rdy_i(rdyA), .free_vld_i(fvldA), .free_vec_i(fvecA),
    .alloc_vld_o(vldF), .alloc_idx_o(idxF), .alloc_vec_o(vecF), .busy_o(busyF),
    .count_o(cntF), .full_o(fullF), .empty_o(emptyF), .err_o(errF));

  e_alloc #(.W(12), .RADIX_N(3), .RR(1)) dutB (
    .clk(clk), .arst_n(arst_n), .alloc_rdy_i(rdyB), .free_vld_i(fvldB), .free_vec_i(fvecB),
    .alloc_vld_o(vldB), .alloc_idx_o(idxB), .alloc_vec_o(vecB), .busy_o(busyB),
    .count_o(cntB), .full_o(fullB), .empty_o(emptyB), .err_o(errB));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          w;
    bit          rr;
    logic [15:0] busy;
    int          ptr;
    logic        err;
  } model_t;

  typedef struct {
    string       tag;
    int          dut;
    logic [51:0] snap;
  } exp_t;

  model_t mA, mF, mB;
  exp_t   sbq[$];
  int     nChecks = 0;
  int     nErr    = 0;

  function automatic model_t mreset(input int w, input bit rr);
    model_t m;
    m.w = w; m.rr = rr; m.busy = '0; m.ptr = 0; m.err = 1'b0;
    return m;
  endfunction

  function automatic int msearch(input model_t m);
    int j;
    for (int k = 0; k < m.w; k++) begin
      j = (m.ptr + k) % m.w;
      if (!m.busy[j]) return j;
    end
    return -1;
  endfunction

  function automatic model_t mstep(input model_t m, input logic rdy, input logic fvld,
                                   input logic [15:0] fvec);
    model_t n;
    int     s;
    n = m;
    n.err = 1'b0;
    s = msearch(m);
    if (fvld) begin
      for (int i = 0; i < m.w; i++) begin
        if (fvec[i]) begin
          if (m.busy[i]) n.busy[i] = 1'b0;
          else n.err = 1'b1;
        end
      end
    end
    if (rdy && s >= 0) begin
      n.busy[s] = 1'b1;
      if (m.rr) n.ptr = (s + 1) % m.w;
    end
    return n;
  endfunction

  function automatic logic [51:0] mkSnap(input logic v, input logic [7:0] idx,
                                         input logic [15:0] vec, input logic [15:0] busy,
                                         input logic [7:0] cnt, input logic f,
                                         input logic e, input logic er);
    return {v, idx, vec, busy, cnt, f, e, er};
  endfunction

  function automatic logic [51:0] expSnap(input model_t m);
    int   cnt, s;
    logic v;
    cnt = $countones(m.busy);
    s = msearch(m);
    v = (cnt < m.w);
    if (!v) s = 0;
    return mkSnap(v, 8'(s), v ? (16'd1 << s) : 16'd0, m.busy, 8'(cnt),
                  cnt == m.w, cnt == 0, m.err);
  endfunction

  task automatic pushAll(input string tag);
    exp_t e;
    e.tag = {tag, "/A"}; e.dut = 0; e.snap = expSnap(mA); sbq.push_back(e);
    e.tag = {tag, "/F"}; e.dut = 1; e.snap = expSnap(mF); sbq.push_back(e);
    e.tag = {tag, "/B"}; e.dut = 2; e.snap = expSnap(mB); sbq.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t        e;
    logic [51:0] obs;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      case (e.dut)
        0: obs = mkSnap(vldA, 8'(idxA), 16'(vecA), 16'(busyA), 8'(cntA), fullA, emptyA, errA);
        1: obs = mkSnap(vldF, 8'(idxF), 16'(vecF), 16'(busyF), 8'(cntF), fullF, emptyF, errF);
        default: obs = mkSnap(vldB, 8'(idxB), 16'(vecB), 16'(busyB), 8'(cntB), fullB, emptyB, errB);
      endcase
      nChecks++;
      assert (obs === e.snap) else begin
        nErr++;
        $error("[TB] FAIL %s: observed=%h expected=%h", e.tag, obs, e.snap);
      end
    end
  endtask

  task automatic checkVal(input string tag, input int obs, input int exp);
    nChecks++;
    assert (obs === exp) else begin
      nErr++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of requests, predict the post-edge state, then compare after the edge.
  task automatic applyStimulus(input string tag, input logic ra, input logic fa,
                               input logic [7:0] va, input logic rb, input logic fb,
                               input logic [11:0] vb);
    rdyA = ra; fvldA = fa; fvecA = va;
    rdyB = rb; fvldB = fb; fvecB = vb;
    if (arst_n) begin
      mA = mstep(mA, ra, fa, 16'(va));
      mF = mstep(mF, ra, fa, 16'(va));
      mB = mstep(mB, rb, fb, 16'(vb));
    end
    pushAll(tag);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic resetModels();
    mA = mreset(8, 1'b1);
    mF = mreset(8, 1'b0);
    mB = mreset(12, 1'b1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    arst_n = 1'b0;
    rdyA = 1'b0; fvldA = 1'b0; fvecA = '0;
    rdyB = 1'b0; fvldB = 1'b0; fvecB = '0;
    resetModels();
    #3;
    pushAll("por");
    checkOutput();
    #9 arst_n = 1'b1;
    checkVal("rel vld", int'(vldA), 1);
    checkVal("rel idx", int'(idxA), 0);
    checkVal("rel cnt", int'(cntA), 0);
    checkVal("rel empty", int'(emptyA), 1);
    applyStimulus("idle", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 12'h000);

    for (int i = 0; i < 8; i++) begin
      checkVal($sformatf("fill idx%0d", i), int'(idxA), i);
      applyStimulus("fill", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 12'h000);
    end
    checkVal("full flag", int'(fullA), 1);
    checkVal("full vld", int'(vldA), 0);
    checkVal("full cnt", int'(cntA), 8);
    checkVal("full busy", int'(busyA), 8'hFF);

    applyStimulus("rdy@full", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 12'h000);
    checkVal("rdy@full err", int'(errA), 0);

    applyStimulus("free04", 1'b0, 1'b1, 8'h04, 1'b0, 1'b0, 12'h000);
    checkVal("free04 vld", int'(vldA), 1);
    checkVal("free04 idx", int'(idxA), 2);
    checkVal("free04 cnt", int'(cntA), 7);
    checkVal("free04 err", int'(errA), 0);

    applyStimulus("freeFA", 1'b0, 1'b1, 8'hFA, 1'b0, 1'b0, 12'h000);
    checkVal("freeFA busy", int'(busyA), 8'h01);
    applyStimulus("free21", 1'b0, 1'b1, 8'h21, 1'b0, 1'b0, 12'h000);
    checkVal("free21 busy", int'(busyA), 8'h00);
    checkVal("free21 err", int'(errA), 1);
    checkVal("free21 cnt", int'(cntA), 0);
    applyStimulus("idle", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 12'h000);
    checkVal("err pulse end", int'(errA), 0);

    for (int i = 0; i < 3; i++) applyStimulus("pre", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 12'h000);
    checkVal("pre busy", int'(busyA), 8'h07);
    checkVal("pre idx", int'(idxA), 3);
    applyStimulus("acc+free01", 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 12'h000);
    checkVal("acc+free busy", int'(busyA), 8'h0E);
    checkVal("acc+free cnt", int'(cntA), 3);
    checkVal("acc+free idx rr", int'(idxA), 4);
    checkVal("acc+free idx fixed", int'(idxF), 0);
    checkVal("acc+free busy fixed", int'(busyF), 8'h0E);

    applyStimulus("accInFree", 1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 12'h000);
    checkVal("accInFree busyA", int'(busyA), 8'h1E);
    checkVal("accInFree errA", int'(errA), 1);
    checkVal("accInFree busyF", int'(busyF), 8'h0F);
    checkVal("accInFree errF", int'(errF), 1);

    checkVal("bypass pre idxF", int'(idxF), 4);
    applyStimulus("bypass", 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 12'h000);
    checkVal("bypass busyF", int'(busyF), 8'h1E);
    checkVal("bypass idxF", int'(idxF), 0);

    for (int i = 0; i < 24; i++) begin
      applyStimulus("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    8'($urandom), 1'b0, 1'b0, 12'h000);
    end

    rdyA = 1'b1; fvldA = 1'b1; fvecA = 8'hFF; rdyB = 1'b1;
    arst_n = 1'b0;
    #1;
    resetModels();
    pushAll("arst async");
    checkOutput();
    @(posedge clk);
    #1;
    pushAll("arst held");
    checkOutput();
    #2 arst_n = 1'b1;
    checkVal("post-rst idx", int'(idxA), 0);
    applyStimulus("first", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 12'h000);
    checkVal("first busy", int'(busyA), 8'h01);

    for (int i = 0; i < 12; i++) begin
      checkVal($sformatf("bfill idx%0d", i), int'(idxB), i);
      applyStimulus("bfill", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 12'h000);
    end
    checkVal("bfull flag", int'(fullB), 1);
    checkVal("bfull cnt", int'(cntB), 12);
    applyStimulus("bfree11", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 12'h800);
    checkVal("bfree11 idx", int'(idxB), 11);
    applyStimulus("bacc11", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 12'h000);
    applyStimulus("bfree11b", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 12'h800);
    checkVal("bfree11b idx", int'(idxB), 11);
    applyStimulus("bfree0", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 12'h001);
    checkVal("bwrap idx", int'(idxB), 0);
    applyStimulus("bacc0", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 12'h000);
    checkVal("bacc0 idx", int'(idxB), 11);

    rdyB = 1'b1;
    arst_n = 1'b0;
    #1;
    resetModels();
    pushAll("b arst");
    checkOutput();
    checkVal("b arst cnt", int'(cntB), 0);
    checkVal("b arst vec", int'(vecB), 1);
    #2 arst_n = 1'b1;
    applyStimulus("end idle", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 12'h000);

    $display("Result: errors=%0d of %0d checks", nErr, nChecks);
    $finish;
  end

endmodule
